// File: rtl/vga_frame_receiver.sv
// vga_frame_receiver: recovers pixel coordinates from VGA sync, checks line/frame timing and CRCs each frame.
// Define VGA_RX_PROBE_EN to add the PROBE_X/PROBE_Y/PROBE_COLOR pixel probe.
module vga_frame_receiver #(
   parameter int H_ACTIVE = 800,
   parameter int H_TOTAL  = 1056,
   parameter int H_SB     = 216,
   parameter int V_ACTIVE = 600,
   parameter int V_TOTAL  = 628,
   parameter int V_SB     = 27,
   parameter bit SYNC_POL = 1'b1
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [7:0]  COLOR,
   input  logic        HSYNC,
   input  logic        VSYNC,
`ifdef VGA_RX_PROBE_EN
   input  logic [9:0]  PROBE_X,
   input  logic [9:0]  PROBE_Y,
   output logic [7:0]  PROBE_COLOR,
`endif
   output logic        LOCKED,
   output logic        FRAME_DONE,
   output logic [15:0] FRAME_CRC,
   output logic        TIMING_ERR
);
   localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_BEG  = 11'(H_SB);
   localparam logic [10:0] H_END  = 11'(H_SB + H_ACTIVE);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_BEG  = 10'(V_SB);
   localparam logic [9:0]  V_END  = 10'(V_SB + V_ACTIVE);

   typedef enum logic [1:0] {ST_HUNT, ST_MEASURE, ST_LOCKED} state_t;

   state_t      state;
   logic        h_s1, h_s2, v_s1, v_s2;
   logic [7:0]  c_s1, c_s2;
   logic [10:0] hcnt;
   logic [9:0]  vcnt;
   logic        vfirst, hseen, bad;
   logic [15:0] crc, crc_last;
   logic        ev_v, ev_l, ev_f;
   logic        hedge, vedge, active, lerr, ferr, good_v;

   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 7; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
      return r;
   endfunction

   assign hedge  = h_s1 & ~h_s2;
   assign vedge  = v_s1 & ~v_s2;
   assign active = (hcnt >= H_BEG) & (hcnt < H_END) & (vcnt >= V_BEG) & (vcnt < V_END);
   assign lerr   = hedge & hseen & (hcnt != H_LAST);
   assign ferr   = vedge & (vcnt != V_LAST);
   assign good_v = ev_v & ~ev_l & ~ev_f;

   // hcnt/vcnt pair with the s2 pixel, so x=0 is H_SB clocks after the HSYNC leading edge
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         {h_s1, h_s2, v_s1, v_s2} <= '0;
         c_s1     <= '0;
         c_s2     <= '0;
         hcnt     <= '0;
         vcnt     <= '0;
         vfirst   <= 1'b0;
         hseen    <= 1'b0;
         crc      <= 16'hFFFF;
         crc_last <= '0;
         {ev_v, ev_l, ev_f} <= '0;
      end else begin
         h_s1     <= HSYNC == SYNC_POL;
         h_s2     <= h_s1;
         v_s1     <= VSYNC == SYNC_POL;
         v_s2     <= v_s1;
         c_s1     <= COLOR;
         c_s2     <= c_s1;
         hcnt     <= hedge ? '0 : hcnt + {10'd0, hcnt != '1};
         vcnt     <= hedge ? ((vfirst | vedge) ? '0 : vcnt + {9'd0, vcnt != '1}) : vcnt;
         vfirst   <= hedge ? 1'b0 : (vfirst | vedge);
         hseen    <= (state == ST_HUNT) ? 1'b0 : (hseen | hedge);
         crc      <= vedge ? 16'hFFFF : active ? crc_byte(crc, c_s2) : crc;
         crc_last <= crc;
         ev_v     <= vedge;
         ev_l     <= lerr;
         ev_f     <= ferr;
      end
   end

   // bad marks a frame already tainted by a line error, so it cannot count as the clean lock frame
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state      <= ST_HUNT;
         bad        <= 1'b0;
         LOCKED     <= 1'b0;
         FRAME_DONE <= 1'b0;
         FRAME_CRC  <= '0;
         TIMING_ERR <= 1'b0;
      end else begin
         FRAME_DONE <= 1'b0;
         TIMING_ERR <= 1'b0;
         case (state)
            ST_HUNT: begin
               bad <= 1'b0;
               if (ev_v) state <= ST_MEASURE;
            end
            ST_MEASURE: begin
               bad <= ~ev_v & (bad | ev_l);
               if (good_v & ~bad) begin
                  state  <= ST_LOCKED;
                  LOCKED <= 1'b1;
               end
            end
            default: begin
               if (ev_l | ev_f) begin
                  state      <= ST_MEASURE;
                  LOCKED     <= 1'b0;
                  TIMING_ERR <= 1'b1;
                  bad        <= ~ev_v;
               end else if (ev_v) begin
                  FRAME_DONE <= 1'b1;
                  FRAME_CRC  <= crc_last;
               end
            end
         endcase
      end
   end

`ifdef VGA_RX_PROBE_EN
   logic [7:0] shadow;
   logic       hit;

   assign hit = active & ((hcnt - H_BEG) == {1'b0, PROBE_X}) & ((vcnt - V_BEG) == PROBE_Y);

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         shadow      <= '0;
         PROBE_COLOR <= '0;
      end else begin
         if (hit) shadow <= c_s2;
         if (state == ST_LOCKED && good_v) PROBE_COLOR <= shadow;
      end
   end
`endif
endmodule

// File: tb/tb_vga_frame_receiver.sv
// tb_vga_frame_receiver: drives scaled-down VGA frames with random colour and checks
// lock, CRC, timing-error and reset behaviour against a raster-order model.
module tb_vga_frame_receiver;
   localparam int HA = 16, HT = 40, HB = 12, HSW = 6;
   localparam int VA = 10, VT = 16, VB = 4, VSW = 2;

   logic        CLK = 1'b0, RST_N = 1'b0, HSYNC = 1'b0, VSYNC = 1'b0;
   logic [7:0]  COLOR = 8'h00;
   logic        LOCKED, FRAME_DONE, TIMING_ERR;
   logic [15:0] FRAME_CRC;
`ifdef VGA_RX_PROBE_EN
   logic [9:0]  PROBE_X = '0, PROBE_Y = '0;
   logic [7:0]  PROBE_COLOR;
`endif

   int n_cmp = 0, n_err = 0, cyc = 0;
   int fd_cnt = 0, te_cnt = 0, fd_cyc = -1, te_cyc = -1, lock_cyc = -1, vs_cyc = 0;
   logic lk_prev = 1'b0;
   logic [15:0] cur_crc = 16'hFFFF, prev_crc = 16'hFFFF;

   vga_frame_receiver #(
      .H_ACTIVE(HA), .H_TOTAL(HT), .H_SB(HB),
      .V_ACTIVE(VA), .V_TOTAL(VT), .V_SB(VB), .SYNC_POL(1'b1)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .COLOR(COLOR), .HSYNC(HSYNC), .VSYNC(VSYNC),
`ifdef VGA_RX_PROBE_EN
      .PROBE_X(PROBE_X), .PROBE_Y(PROBE_Y), .PROBE_COLOR(PROBE_COLOR),
`endif
      .LOCKED(LOCKED), .FRAME_DONE(FRAME_DONE), .FRAME_CRC(FRAME_CRC), .TIMING_ERR(TIMING_ERR)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (FRAME_DONE) begin fd_cnt <= fd_cnt + 1; fd_cyc <= cyc; end
      if (TIMING_ERR) begin te_cnt <= te_cnt + 1; te_cyc <= cyc; end
      if (LOCKED && !lk_prev) lock_cyc <= cyc;
      lk_prev <= LOCKED;
   end

   // byte-wise CRC-16-CCITT: xor byte into the high half, then eight shift/reduce steps
   function automatic logic [15:0] crc_ccitt(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {b, 8'h00};
      for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      return r;
   endfunction

   // mode: 0 all 0x00, 1 all 0xFF, 2 random, 3 pc at active (px,py) else 0x00
   task automatic drive_lines(input int first, input int last, input int short_l, input int mode,
                              input int px, input int py, input logic [7:0] pc);
      for (int l = first; l < last; l++)
         for (int c = 0; c < ((l == short_l) ? HT - 1 : HT); c++) begin
            @(negedge CLK);
            if (l == 0 && c == 0) begin
               prev_crc = cur_crc;
               cur_crc  = 16'hFFFF;
               vs_cyc   = cyc + 1;
            end
            HSYNC = c < HSW;
            VSYNC = l < VSW;
            COLOR = (mode == 0) ? 8'h00 : (mode == 1) ? 8'hFF : (mode == 2) ? 8'($urandom) :
                    (c - HB == px && l - VB == py) ? pc : 8'h00;
            if (l >= VB && l < VB + VA && c >= HB && c < HB + HA) cur_crc = crc_ccitt(cur_crc, COLOR);
         end
   endtask

   task automatic frame(input int mode);
      drive_lines(0, VT, -1, mode, 0, 0, 8'h00);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         HSYNC = 1'b0;
         VSYNC = 1'b0;
         COLOR = 8'($urandom);
      end
   endtask

   task automatic test_reset;
      RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      n_cmp++; if (LOCKED !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %b want 0", LOCKED); end
      n_cmp++; if (FRAME_DONE !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", FRAME_DONE); end
      n_cmp++; if (TIMING_ERR !== 1'b0) begin n_err++; $display("FAIL reset_terr: got %b want 0", TIMING_ERR); end
      n_cmp++; if (FRAME_CRC !== 16'h0000) begin n_err++; $display("FAIL reset_crc: got %h want 0000", FRAME_CRC); end
`ifdef VGA_RX_PROBE_EN
      n_cmp++; if (PROBE_COLOR !== 8'h00) begin n_err++; $display("FAIL reset_probe: got %h want 00", PROBE_COLOR); end
`endif
      RST_N = 1'b1;
      idle(5);
   endtask

   task automatic test_lock;
      int fd0, te0;
      fd0 = fd_cnt; te0 = te_cnt;
      frame(0);
      n_cmp++; if (LOCKED !== 1'b0) begin n_err++; $display("FAIL lock_early: got %b want 0", LOCKED); end
      frame(0);
      n_cmp++; if (lock_cyc !== vs_cyc + 2) begin n_err++; $display("FAIL lock_latency: got %0d want %0d", lock_cyc, vs_cyc + 2); end
      n_cmp++; if (LOCKED !== 1'b1) begin n_err++; $display("FAIL lock_level: got %b want 1", LOCKED); end
      n_cmp++; if (fd_cnt !== fd0) begin n_err++; $display("FAIL lock_no_done: got %0d want %0d", fd_cnt, fd0); end
      n_cmp++; if (te_cnt !== te0) begin n_err++; $display("FAIL lock_no_terr: got %0d want %0d", te_cnt, te0); end
   endtask

   task automatic test_crc_ff;
      int fd0;
      fd0 = fd_cnt;
      frame(1);
      n_cmp++; if (FRAME_CRC !== prev_crc) begin n_err++; $display("FAIL crc_zero: got %h want %h", FRAME_CRC, prev_crc); end
      frame(2);
      n_cmp++; if (FRAME_CRC !== prev_crc) begin n_err++; $display("FAIL crc_ff: got %h want %h", FRAME_CRC, prev_crc); end
      n_cmp++; if (fd_cnt !== fd0 + 2) begin n_err++; $display("FAIL done_width: got %0d want %0d", fd_cnt, fd0 + 2); end
      n_cmp++; if (fd_cyc !== vs_cyc + 2) begin n_err++; $display("FAIL done_latency: got %0d want %0d", fd_cyc, vs_cyc + 2); end
   endtask

   task automatic test_random;
      int fd0, te0;
      te0 = te_cnt;
      for (int i = 0; i < 3; i++) begin
         fd0 = fd_cnt;
         frame(2);
         n_cmp++; if (FRAME_CRC !== prev_crc) begin n_err++; $display("FAIL crc_rand%0d: got %h want %h", i, FRAME_CRC, prev_crc); end
         n_cmp++; if (fd_cnt !== fd0 + 1) begin n_err++; $display("FAIL done_rand%0d: got %0d want %0d", i, fd_cnt, fd0 + 1); end
      end
      n_cmp++; if (te_cnt !== te0) begin n_err++; $display("FAIL rand_terr: got %0d want %0d", te_cnt, te0); end
   endtask

   task automatic test_short_line;
      int fd0, te0;
      fd0 = fd_cnt; te0 = te_cnt;
      drive_lines(0, VT, 5, 2, 0, 0, 8'h00);
      n_cmp++; if (te_cnt !== te0 + 1) begin n_err++; $display("FAIL sl_terr: got %0d want %0d", te_cnt, te0 + 1); end
      n_cmp++; if (LOCKED !== 1'b0) begin n_err++; $display("FAIL sl_unlock: got %b want 0", LOCKED); end
      frame(2);
      n_cmp++; if (fd_cnt !== fd0 + 1) begin n_err++; $display("FAIL sl_no_done: got %0d want %0d", fd_cnt, fd0 + 1); end
      n_cmp++; if (LOCKED !== 1'b0) begin n_err++; $display("FAIL sl_tainted: got %b want 0", LOCKED); end
      frame(2);
      n_cmp++; if (LOCKED !== 1'b1) begin n_err++; $display("FAIL sl_relock: got %b want 1", LOCKED); end
      n_cmp++; if (te_cnt !== te0 + 1 || fd_cnt !== fd0 + 1) begin n_err++; $display("FAIL sl_counts: got te %0d fd %0d want te %0d fd %0d", te_cnt, fd_cnt, te0 + 1, fd0 + 1); end
   endtask

   task automatic test_short_frame;
      int te0;
      te0 = te_cnt;
      drive_lines(0, VT - 1, -1, 2, 0, 0, 8'h00);
      frame(2);
      n_cmp++; if (te_cnt !== te0 + 1) begin n_err++; $display("FAIL sf_terr: got %0d want %0d", te_cnt, te0 + 1); end
      n_cmp++; if (te_cyc !== vs_cyc + 2) begin n_err++; $display("FAIL sf_latency: got %0d want %0d", te_cyc, vs_cyc + 2); end
      n_cmp++; if (LOCKED !== 1'b0) begin n_err++; $display("FAIL sf_unlock: got %b want 0", LOCKED); end
      frame(2);
      n_cmp++; if (LOCKED !== 1'b1) begin n_err++; $display("FAIL sf_measure_relock: got %b want 1", LOCKED); end
   endtask

`ifdef VGA_RX_PROBE_EN
   task automatic test_probe;
      PROBE_X = 10'(HA - 1); PROBE_Y = 10'(VA - 1);
      drive_lines(0, VT, -1, 3, HA - 1, VA - 1, 8'hA5);
      PROBE_X = '0; PROBE_Y = '0;
      drive_lines(0, VT, -1, 3, 0, 0, 8'h3C);
      n_cmp++; if (PROBE_COLOR !== 8'hA5) begin n_err++; $display("FAIL probe_last: got %h want a5", PROBE_COLOR); end
      n_cmp++; if (FRAME_CRC !== prev_crc) begin n_err++; $display("FAIL probe_crc: got %h want %h", FRAME_CRC, prev_crc); end
      frame(0);
      n_cmp++; if (PROBE_COLOR !== 8'h3C) begin n_err++; $display("FAIL probe_origin: got %h want 3c", PROBE_COLOR); end
   endtask
`endif

   task automatic test_mid_reset;
      int fd0;
      drive_lines(0, 8, -1, 2, 0, 0, 8'h00);
      @(negedge CLK); RST_N = 1'b0; HSYNC = 1'b0;
      @(negedge CLK); RST_N = 1'b1;
      n_cmp++; if (LOCKED !== 1'b0) begin n_err++; $display("FAIL mr_locked: got %b want 0", LOCKED); end
      n_cmp++; if (FRAME_CRC !== 16'h0000) begin n_err++; $display("FAIL mr_crc: got %h want 0000", FRAME_CRC); end
      fd0 = fd_cnt;
      drive_lines(8, VT, -1, 2, 0, 0, 8'h00);
      frame(2);
      n_cmp++; if (LOCKED !== 1'b0) begin n_err++; $display("FAIL mr_hunt: got %b want 0", LOCKED); end
      frame(2);
      n_cmp++; if (LOCKED !== 1'b1) begin n_err++; $display("FAIL mr_relock: got %b want 1", LOCKED); end
      n_cmp++; if (fd_cnt !== fd0) begin n_err++; $display("FAIL mr_no_done: got %0d want %0d", fd_cnt, fd0); end
      frame(2);
      n_cmp++; if (FRAME_CRC !== prev_crc) begin n_err++; $display("FAIL mr_crc_after: got %h want %h", FRAME_CRC, prev_crc); end
   endtask

   task automatic test_idle_saturate;
      int fd0, te0;
      fd0 = fd_cnt; te0 = te_cnt;
      idle(2048);
      n_cmp++; if (fd_cnt !== fd0 || te_cnt !== te0) begin n_err++; $display("FAIL idle_pulses: got fd %0d te %0d want fd %0d te %0d", fd_cnt, te_cnt, fd0, te0); end
      n_cmp++; if (LOCKED !== 1'b1) begin n_err++; $display("FAIL idle_hold: got %b want 1", LOCKED); end
      frame(2);
      n_cmp++; if (te_cnt !== te0 + 1) begin n_err++; $display("FAIL sat_terr: got %0d want %0d", te_cnt, te0 + 1); end
      n_cmp++; if (LOCKED !== 1'b0 || fd_cnt !== fd0) begin n_err++; $display("FAIL sat_state: got lk %b fd %0d want lk 0 fd %0d", LOCKED, fd_cnt, fd0); end
   endtask

   initial begin
      test_reset;
      test_lock;
      test_crc_ff;
      test_random;
      test_short_line;
      test_short_frame;
`ifdef VGA_RX_PROBE_EN
      test_probe;
`endif
      test_mid_reset;
      test_idle_saturate;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
